mem_stage: RTL and testbench

- Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back.
- Latches one instruction per valid/allowin handshake and issues at most one data-SRAM request (req/addr_ok/data_ok protocol).
- Aligns and extends load data, builds store strobes, and forwards the final result, exception info and a bypass bus to write-back and decode.
- Absorbs late responses after a flush, so no stale data reaches the pipeline.

---
 rtl/mem_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Memory-access pipeline stage: one data-SRAM request per
//            instruction, load alignment/extension, flush-safe response drain.
//            Optional macro MEM_ALE_CHECK_EN enables misaligned-access faults.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int EXCP_W  = 16,
  parameter int ALE_BIT = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_sign,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  output logic              ms_to_ws_valid,
  input  logic              ws_allowin,
  input  logic [31:0]       es_alu_result,
  input  logic [31:0]       es_rkd_value,
  input  logic [9:0]        es_mem_op,
  input  logic              es_gr_we,
  input  logic [4:0]        es_dest,
  input  logic [31:0]       es_pc,
  input  logic              es_excp,
  input  logic [EXCP_W-1:0] es_excp_num,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [31:0]       data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic [31:0]       ms_final_result,
  output logic              ms_gr_we,
  output logic [4:0]        ms_dest,
  output logic [31:0]       ms_pc,
  output logic              ms_excp,
  output logic [EXCP_W-1:0] ms_excp_num,
  output logic [38:0]       ms_bypass,
  output logic              ms_bypass_ready,
  output logic              ms_excp_up
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              ms_valid_q, ms_valid_d;
  logic [31:0]       addr_q, rkd_q, pc_q, rdata_q;
  logic [7:0]        op_q;
  logic              gr_we_q, excp_q;
  logic [4:0]        dest_q;
  logic [EXCP_W-1:0] excp_num_q;

  logic              ms_ready_go, req_raw, latch, ale, excp_in, need_mem;
  logic [EXCP_W-1:0] ale_vec, excp_num_in;
  logic              is_load_q, is_store_q, is_byte_q, is_half_q, is_word_q;
  logic [31:0]       rdata_sh, load_val;
  logic              unused_bits;

  assign unused_bits = ^es_mem_op[9:8];

`ifdef MEM_ALE_CHECK_EN
  // An older exception takes priority over the alignment fault.
  assign ale = !es_excp &&
               (((es_mem_op[2] | es_mem_op[3] | es_mem_op[6]) && es_alu_result[0]) ||
                ((es_mem_op[4] | es_mem_op[7]) && (es_alu_result[1:0] != 2'b00)));
`else
  assign ale = 1'b0;
`endif

  always_comb begin
    ale_vec          = '0;
    ale_vec[ALE_BIT] = ale;
  end

  assign excp_in     = es_excp | ale;
  assign excp_num_in = es_excp_num | ale_vec;
  assign need_mem    = (|es_mem_op[7:0]) && !excp_in;
  assign latch       = es_to_ms_valid && ms_allowin && !flush_sign;

  assign is_load_q  = |op_q[4:0];
  assign is_store_q = |op_q[7:5];
  assign is_byte_q  = op_q[0] | op_q[1] | op_q[5];
  assign is_half_q  = op_q[2] | op_q[3] | op_q[6];
  assign is_word_q  = op_q[4] | op_q[7];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ms_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_valid_q <= ms_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (latch) state_d = need_mem ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        // A flush coinciding with addr_ok still leaves a load response in flight.
        if (flush_sign)             state_d = (data_sram_addr_ok && is_load_q) ? S_DRAIN : S_IDLE;
        else if (data_sram_addr_ok) state_d = is_load_q ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (data_sram_data_ok) state_d = flush_sign ? S_IDLE : S_DONE;
        else if (flush_sign)   state_d = S_DRAIN;
      end
      S_DONE: begin
        if (flush_sign)      state_d = S_IDLE;
        else if (latch)      state_d = need_mem ? S_REQ : S_IDLE;
        else if (ws_allowin) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (data_sram_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ms_ready_go = (state_q == S_DONE) || ((state_q == S_IDLE) && ms_valid_q);
    req_raw     = (state_q == S_REQ);
    ms_allowin  = (state_q != S_DRAIN) && (!ms_valid_q || (ms_ready_go && ws_allowin));
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush_sign)      ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_sign) begin
      addr_q     <= '0;
      rkd_q      <= '0;
      op_q       <= '0;
      gr_we_q    <= 1'b0;
      dest_q     <= '0;
      pc_q       <= '0;
      excp_q     <= 1'b0;
      excp_num_q <= '0;
    end else if (latch) begin
      addr_q     <= es_alu_result;
      rkd_q      <= es_rkd_value;
      op_q       <= es_mem_op[7:0];
      gr_we_q    <= es_gr_we;
      dest_q     <= es_dest;
      pc_q       <= es_pc;
      excp_q     <= excp_in;
      excp_num_q <= excp_num_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_sign)                             rdata_q <= '0;
    else if ((state_q == S_WAIT) && data_sram_data_ok) rdata_q <= data_sram_rdata;
  end

  always_comb begin
    data_sram_size  = is_word_q ? 2'd2 : (is_half_q ? 2'd1 : 2'd0);
    data_sram_wstrb = 4'h0;
    data_sram_wdata = rkd_q;
    if (is_byte_q)      data_sram_wdata = {4{rkd_q[7:0]}};
    else if (is_half_q) data_sram_wdata = {2{rkd_q[15:0]}};
    if (is_store_q) begin
      if (is_byte_q)      data_sram_wstrb = 4'b0001 << addr_q[1:0];
      else if (is_half_q) data_sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      else                data_sram_wstrb = 4'hF;
    end
  end

  always_comb begin
    rdata_sh = rdata_q >> {addr_q[1:0], 3'b000};
    load_val = rdata_sh;
    if (op_q[0])      load_val = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
    else if (op_q[1]) load_val = {24'h0, rdata_sh[7:0]};
    else if (op_q[2]) load_val = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
    else if (op_q[3]) load_val = {16'h0, rdata_sh[15:0]};
  end

  assign data_sram_req   = req_raw && !flush_sign && !excp_q;
  assign data_sram_wr    = is_store_q;
  assign data_sram_addr  = addr_q;
  assign ms_final_result = (is_load_q && !excp_q) ? load_val : addr_q;
  assign ms_to_ws_valid  = ms_valid_q && ms_ready_go && !flush_sign;
  assign ms_gr_we        = gr_we_q;
  assign ms_dest         = dest_q;
  assign ms_pc           = pc_q;
  assign ms_excp         = excp_q;
  assign ms_excp_num     = excp_num_q;
  assign ms_bypass       = {ms_valid_q, gr_we_q, dest_q, ms_final_result};
  assign ms_bypass_ready = ms_valid_q && ms_ready_go;
  assign ms_excp_up      = ms_valid_q && excp_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  localparam int EXCP_W = 16;
  localparam logic [9:0] LD_B  = 10'h001;
  localparam logic [9:0] LD_BU = 10'h002;
  localparam logic [9:0] LD_H  = 10'h004;
  localparam logic [9:0] LD_HU = 10'h008;
  localparam logic [9:0] LD_W  = 10'h010;
  localparam logic [9:0] ST_B  = 10'h020;
  localparam logic [9:0] ST_H  = 10'h040;

  logic              clk = 1'b0;
  logic              rst, flush_sign, es_to_ms_valid, ws_allowin;
  logic              ms_allowin, ms_to_ws_valid;
  logic [31:0]       es_alu_result, es_rkd_value, es_pc;
  logic [9:0]        es_mem_op;
  logic              es_gr_we, es_excp;
  logic [4:0]        es_dest;
  logic [EXCP_W-1:0] es_excp_num;
  logic              data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]        data_sram_size;
  logic [3:0]        data_sram_wstrb;
  logic [31:0]       data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [31:0]       ms_final_result, ms_pc;
  logic              ms_gr_we, ms_excp, ms_bypass_ready, ms_excp_up;
  logic [4:0]        ms_dest;
  logic [EXCP_W-1:0] ms_excp_num;
  logic [38:0]       ms_bypass;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.EXCP_W(EXCP_W), .ALE_BIT(9)) dut (
    .clk(clk), .rst(rst), .flush_sign(flush_sign),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .es_alu_result(es_alu_result), .es_rkd_value(es_rkd_value), .es_mem_op(es_mem_op),
    .es_gr_we(es_gr_we), .es_dest(es_dest), .es_pc(es_pc),
    .es_excp(es_excp), .es_excp_num(es_excp_num),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .ms_final_result(ms_final_result), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_pc(ms_pc), .ms_excp(ms_excp), .ms_excp_num(ms_excp_num),
    .ms_bypass(ms_bypass), .ms_bypass_ready(ms_bypass_ready), .ms_excp_up(ms_excp_up)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [9:0] op, input logic [31:0] addr, input logic [31:0] rkd);
    es_mem_op      = op;
    es_alu_result  = addr;
    es_rkd_value   = rkd;
    es_gr_we       = !(|op[7:5]);
    es_dest        = 5'd7;
    es_pc          = 32'h1c00_0000 + addr;
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    #1;
  endtask

  task automatic load_run(input string tag, input logic [9:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    issue(op, addr, 32'h0);
    chk({tag, "_req"}, data_sram_req, 1);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    chk({tag, "_valid"}, ms_to_ws_valid, 1);
    chk({tag, "_result"}, ms_final_result, exp);
    step();
  endtask

  task automatic store_run(input string tag, input logic [9:0] op, input logic [31:0] addr,
                           input logic [31:0] rkd, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [1:0] size);
    issue(op, addr, rkd);
    chk({tag, "_req"}, data_sram_req, 1);
    chk({tag, "_wr"}, data_sram_wr, 1);
    chk({tag, "_wstrb"}, data_sram_wstrb, strb);
    chk({tag, "_wdata"}, data_sram_wdata, wdata);
    chk({tag, "_size"}, data_sram_size, size);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    #1;
    chk({tag, "_done"}, ms_to_ws_valid, 1);
    step();
    chk({tag, "_left"}, ms_to_ws_valid, 0);
  endtask

  initial begin
    rst = 1'b1; flush_sign = 1'b0; es_to_ms_valid = 1'b0; ws_allowin = 1'b1;
    es_alu_result = '0; es_rkd_value = '0; es_pc = '0; es_mem_op = '0;
    es_gr_we = 1'b0; es_dest = '0; es_excp = 1'b0; es_excp_num = '0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    step(); step();
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_to_ws", ms_to_ws_valid, 0);
    chk("rst_req", data_sram_req, 0);
    chk("rst_result", ms_final_result, 0);
    chk("rst_bypass", ms_bypass, 0);
    chk("rst_bypass_ready", ms_bypass_ready, 0);
    rst = 1'b0;
    step();

    // ld_w with addr_ok one cycle after latch and data_ok two cycles later
    issue(LD_W, 32'h1000, 32'h0);
    chk("ldw_req", data_sram_req, 1);
    chk("ldw_addr", data_sram_addr, 32'h1000);
    chk("ldw_size", data_sram_size, 2);
    chk("ldw_wstrb", data_sram_wstrb, 0);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    #1;
    chk("ldw_wait_req", data_sram_req, 0);
    chk("ldw_wait_allowin", ms_allowin, 0);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("ldw_dok_to_ws", ms_to_ws_valid, 0);
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    chk("ldw_to_ws", ms_to_ws_valid, 1);
    chk("ldw_result", ms_final_result, 32'hDEAD_BEEF);
    chk("ldw_bypass", ms_bypass, {1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF});
    chk("ldw_bypass_ready", ms_bypass_ready, 1);
    step();
    chk("ldw_left", ms_to_ws_valid, 0);

    load_run("ldb", LD_B, 32'h1003, 32'h8011_2233, 32'hFFFF_FF80);
    load_run("ldbu", LD_BU, 32'h1003, 32'h8011_2233, 32'h0000_0080);
    load_run("ldhu", LD_HU, 32'h1002, 32'h8011_2233, 32'h0000_8011);
    load_run("ldh", LD_H, 32'h1002, 32'h8011_2233, 32'hFFFF_8011);
    load_run("ldb0", LD_B, 32'h1000, 32'h8011_2233, 32'h0000_0033);

    store_run("sth", ST_H, 32'h2002, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 2'd1);
    store_run("stb", ST_B, 32'h2001, 32'h0000_00EF, 4'b0010, 32'hEFEF_EFEF, 2'd0);

    // Flush while a load response is outstanding; stale data must be dropped
    issue(LD_W, 32'h3000, 32'h0);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    flush_sign = 1'b1;
    #1;
    chk("fl_to_ws", ms_to_ws_valid, 0);
    step();
    flush_sign = 1'b0;
    es_mem_op = LD_W; es_alu_result = 32'h3004; es_to_ms_valid = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    chk("fl_drain_allowin", ms_allowin, 0);
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    chk("fl_stale_to_ws", ms_to_ws_valid, 0);
    chk("fl_after_allowin", ms_allowin, 1);
    load_run("fl_new", LD_W, 32'h3004, 32'h2222_2222, 32'h2222_2222);

    // Flush while the request is pending drops it in the same cycle
    issue(LD_W, 32'h3100, 32'h0);
    flush_sign = 1'b1;
    #1;
    chk("flreq_req", data_sram_req, 0);
    step();
    flush_sign = 1'b0;
    #1;
    chk("flreq_req_after", data_sram_req, 0);
    chk("flreq_allowin", ms_allowin, 1);

    // Misaligned half load
    issue(LD_H, 32'h1001, 32'h0);
`ifdef MEM_ALE_CHECK_EN
    chk("ale_req", data_sram_req, 0);
    chk("ale_excp", ms_excp, 1);
    chk("ale_excp_num", ms_excp_num, 16'h0200);
    chk("ale_result", ms_final_result, 32'h1001);
    chk("ale_to_ws", ms_to_ws_valid, 1);
    step();
`else
    chk("ale_req", data_sram_req, 1);
    chk("ale_addr", data_sram_addr, 32'h1001);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    step();
    data_sram_data_ok = 1'b0;
    #1;
    chk("ale_result", ms_final_result, 32'h0000_3456);
    step();
`endif

    // Upstream exception passes through without a request
    es_excp = 1'b1; es_excp_num = 16'h0004;
    issue(LD_W, 32'h4000, 32'h0);
    es_excp = 1'b0; es_excp_num = '0;
    chk("ex_req", data_sram_req, 0);
    chk("ex_to_ws", ms_to_ws_valid, 1);
    chk("ex_excp_num", ms_excp_num, 16'h0004);
    chk("ex_up", ms_excp_up, 1);
    chk("ex_result", ms_final_result, 32'h4000);
    step();

    // Load data held while write-back stalls
    ws_allowin = 1'b0;
    issue(LD_W, 32'h5000, 32'h0);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    step();
    chk("hold_result", ms_final_result, 32'hCAFE_F00D);
    chk("hold_allowin", ms_allowin, 0);
    ws_allowin = 1'b1;
    step();

    // Non-memory op stalled by write-back for three cycles
    ws_allowin = 1'b0;
    issue(10'h0, 32'h5, 32'h0);
    es_mem_op = 10'h0; es_alu_result = 32'h9; es_to_ms_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_result", ms_final_result, 32'h5);
      chk("stall_allowin", ms_allowin, 0);
      chk("stall_to_ws", ms_to_ws_valid, 1);
      step();
    end
    ws_allowin = 1'b1;
    #1;
    chk("stall_release_allowin", ms_allowin, 1);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    chk("stall_next_result", ms_final_result, 32'h9);
    step();
    chk("stall_empty", ms_to_ws_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
